// File: rtl/matrix_rx.sv
// Receive end of the LED-panel serial interface: synchronises panel pins, deserialises sdo on dclk,
// frames words on le and tracks the row address. Optional gclk-per-row counter: MATRIX_RX_GCLK_COUNT_EN.
module matrix_rx #(
  parameter int unsigned WORD_BITS   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sdo,
  input  logic                 dclk,
  input  logic                 le,
  input  logic                 gclk,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 d,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word_data,
  output logic [3:0]           word_cmd,
  output logic [7:0]           word_bits,
  output logic                 word_ovf,
  output logic [3:0]           row_addr,
  output logic                 row_change,
  output logic [15:0]          row_gclks
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CMD   = 2'd2;
  localparam logic [7:0] LP_WORD_BITS = 8'(WORD_BITS);

  // Pin bundle layout: {d,c,b,a,gclk,le,dclk,sdo}
  logic [7:0] w_pins;
  logic [7:0] r_sync [SYNC_STAGES];
  logic [7:0] r_edge;
  logic [7:0] w_s;

  assign w_pins = {d, c, b, a, gclk, le, dclk, sdo};
  assign w_s    = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
      r_edge <= '0;
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
      r_edge <= w_s;
    end
  end

  logic w_dclk_rise, w_le_rise, w_le_fall, w_row_chg;
  assign w_dclk_rise = w_s[1] & ~r_edge[1];
  assign w_le_rise   = w_s[2] & ~r_edge[2];
  assign w_le_fall   = ~w_s[2] & r_edge[2];
  assign w_row_chg   = (w_s[7:4] != r_edge[7:4]);
  assign row_addr    = r_edge[7:4];

  always_ff @(posedge clk) begin
    if (rst) row_change <= 1'b0;
    else     row_change <= w_row_chg;
  end

  logic [1:0]           r_state, w_state_nxt;
  logic [WORD_BITS-1:0] r_shreg, w_shreg_nxt;
  logic [7:0]           r_bit_cnt, w_bit_nxt;
  logic [3:0]           r_cmd_cnt, w_cmd_nxt;
  logic                 w_in_cmd;

  always_comb begin
    w_shreg_nxt = r_shreg;
    w_bit_nxt   = r_bit_cnt;
    w_cmd_nxt   = r_cmd_cnt;
    w_state_nxt = r_state;
    // A dclk edge coincident with le rising already belongs to the command
    w_in_cmd    = (r_state == ST_CMD) | w_le_rise;
    if (w_dclk_rise) begin
      w_shreg_nxt = {r_shreg[WORD_BITS-2:0], w_s[0]};
      if (r_bit_cnt != 8'hFF) w_bit_nxt = r_bit_cnt + 8'd1;
      if (w_in_cmd && r_cmd_cnt != 4'hF) w_cmd_nxt = r_cmd_cnt + 4'd1;
    end
    if (w_le_rise)                                w_state_nxt = ST_CMD;
    else if (w_le_fall)                           w_state_nxt = ST_IDLE;
    else if (r_state == ST_IDLE && w_dclk_rise)   w_state_nxt = ST_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_cmd_cnt  <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_cmd   <= '0;
      word_bits  <= '0;
      word_ovf   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      word_valid <= w_le_fall;
      if (w_le_fall) begin
        word_data <= w_shreg_nxt;
        word_cmd  <= w_cmd_nxt;
        word_bits <= w_bit_nxt;
        word_ovf  <= (w_bit_nxt > LP_WORD_BITS);
        r_bit_cnt <= '0;
        r_cmd_cnt <= '0;
      end else begin
        r_bit_cnt <= w_bit_nxt;
        r_cmd_cnt <= w_cmd_nxt;
      end
    end
  end

`ifdef MATRIX_RX_GCLK_COUNT_EN
  logic        w_gclk_rise;
  logic [15:0] r_gclk_cnt, w_gclk_inc, r_row_gclks;

  assign w_gclk_rise = w_s[3] & ~r_edge[3];
  assign w_gclk_inc  = (w_gclk_rise && r_gclk_cnt != 16'hFFFF) ? r_gclk_cnt + 16'd1 : r_gclk_cnt;
  assign row_gclks   = r_row_gclks;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gclk_cnt  <= '0;
      r_row_gclks <= '0;
    end else if (w_row_chg) begin
      r_row_gclks <= w_gclk_inc;
      r_gclk_cnt  <= '0;
    end else begin
      r_gclk_cnt  <= w_gclk_inc;
    end
  end
`else
  logic w_unused_gclk;
  assign w_unused_gclk = r_edge[3];
  assign row_gclks     = '0;
`endif

endmodule

// File: tb/tb_matrix_rx.sv
// Self-checking bench for matrix_rx: scoreboarded word checks, row tracking and gclk counting.
module tb_matrix_rx;
  logic        clk = 1'b0;
  logic        rst, sdo, dclk, le, gclk, a, b, c, d;
  logic        word_valid, word_ovf, row_change;
  logic [15:0] word_data, row_gclks;
  logic [3:0]  word_cmd, row_addr;
  logic [7:0]  word_bits;

  matrix_rx #(.WORD_BITS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sdo(sdo), .dclk(dclk), .le(le), .gclk(gclk),
    .a(a), .b(b), .c(c), .d(d),
    .word_valid(word_valid), .word_data(word_data), .word_cmd(word_cmd),
    .word_bits(word_bits), .word_ovf(word_ovf), .row_addr(row_addr),
    .row_change(row_change), .row_gclks(row_gclks)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [15:0] mask;
    logic [3:0]  cmd;
    logic [7:0]  bits;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_rowchg = 0;

  always @(posedge clk) begin
    if (word_valid) n_valid++;
    if (row_change) n_rowchg++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    sdo = v;
    cyc(2);
    dclk = 1'b1;
    cyc(2);
    dclk = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    logic [31:0] t;
    t = w;
    for (int i = n - 1; i >= 0; i--) send_bit(t[i]);
  endtask

  task automatic wait_valid(output bit got, output int lag);
    got = 1'b0;
    lag = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (word_valid) begin
        got = 1'b1;
        lag = i;
      end
    end
  endtask

  task automatic le_pulse();
    cyc(2);
    le = 1'b1;
    cyc(3);
    le = 1'b0;
  endtask

  task automatic compare_word(input string name);
    bit   got;
    int   lag;
    exp_t e;
    wait_valid(got, lag);
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: word_valid not seen within 40 cycles", name);
    end else begin
      checks += 4;
      if ((word_data & e.mask) !== (e.data & e.mask)) begin
        errors++;
        $display("FAIL %s data: got %h expected %h", name, word_data & e.mask, e.data & e.mask);
      end
      if (word_cmd !== e.cmd) begin
        errors++;
        $display("FAIL %s cmd: got %0d expected %0d", name, word_cmd, e.cmd);
      end
      if (word_bits !== e.bits) begin
        errors++;
        $display("FAIL %s bits: got %0d expected %0d", name, word_bits, e.bits);
      end
      if (word_ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s ovf: got %b expected %b", name, word_ovf, e.ovf);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sdo = 0; dclk = 0; le = 0; gclk = 0; {d, c, b, a} = 4'd0;
    cyc(4);
    rst = 1'b0;
    cyc(1);
    checks++;
    if ({word_valid, word_ovf, row_change} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {word_valid, word_ovf, row_change});
    end
    checks++;
    if ({word_data, word_cmd, word_bits} !== 28'd0) begin
      errors++;
      $display("FAIL reset_word: got %h/%h/%h expected 0", word_data, word_cmd, word_bits);
    end
    checks++;
    if ({row_addr, row_gclks} !== 20'd0) begin
      errors++;
      $display("FAIL reset_row: got %h/%h expected 0", row_addr, row_gclks);
    end
  endtask

  task automatic test_word();
    sb.push_back('{data: 16'hA5C3, mask: 16'hFFFF, cmd: 4'd1, bits: 8'd16, ovf: 1'b0});
    send_word(32'h0000_52E1, 15);
    le = 1'b1;
    cyc(4);
    send_bit(1'b1);
    cyc(2);
    le = 1'b0;
    compare_word("word_a5c3");
    @(negedge clk);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++;
      $display("FAIL word_pulse_width: got %b expected 0", word_valid);
    end
  endtask

  task automatic test_cmd();
    sb.push_back('{data: 16'h0005, mask: 16'h0007, cmd: 4'd3, bits: 8'd3, ovf: 1'b0});
    le = 1'b1;
    cyc(4);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    cyc(2);
    le = 1'b0;
    compare_word("cmd3");
  endtask

  task automatic test_overflow();
    sb.push_back('{data: 16'hA5C3, mask: 16'hFFFF, cmd: 4'd0, bits: 8'd20, ovf: 1'b1});
    send_word(32'h000F_A5C3, 20);
    le_pulse();
    compare_word("ovf20");
  endtask

  task automatic test_le_only();
    bit got;
    int lag;
    cyc(2);
    le = 1'b1;
    cyc(4);
    le = 1'b0;
    wait_valid(got, lag);
    checks++;
    if (!got || lag != 3) begin
      errors++;
      $display("FAIL le_only_lag: got valid=%b lag=%0d expected valid=1 lag=3", got, lag);
    end
    checks++;
    if ({word_data, word_cmd, word_bits, word_ovf} !== {16'hA5C3, 4'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL le_only_word: got %h/%h/%h/%b expected a5c3/0/00/0",
               word_data, word_cmd, word_bits, word_ovf);
    end
  endtask

  task automatic test_reset_midword();
    int nv0;
    send_word(32'h0000_00FF, 8);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    checks++;
    if (word_data !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_clear: got %h expected 0000", word_data);
    end
    nv0 = n_valid;
    sb.push_back('{data: 16'h1234, mask: 16'hFFFF, cmd: 4'd0, bits: 8'd16, ovf: 1'b0});
    send_word(32'h0000_1234, 16);
    cyc(4);
    checks++;
    if (n_valid != nv0) begin
      errors++;
      $display("FAIL midreset_no_early: got %0d pulses expected 0", n_valid - nv0);
    end
    le_pulse();
    compare_word("midreset_1234");
  endtask

  task automatic test_row();
    int r0;
    r0 = n_rowchg;
    {d, c, b, a} = 4'd5;
    cyc(2);
    checks++;
    if (row_addr !== 4'd0) begin
      errors++;
      $display("FAIL row_early: got %h expected 0", row_addr);
    end
    cyc(1);
    checks++;
    if ({row_addr, row_change} !== {4'd5, 1'b1}) begin
      errors++;
      $display("FAIL row5: got %h/%b expected 5/1", row_addr, row_change);
    end
    cyc(1);
    checks++;
    if (row_change !== 1'b0) begin
      errors++;
      $display("FAIL row_pulse_width: got %b expected 0", row_change);
    end
    cyc(4);
    {d, c, b, a} = 4'd5;
    cyc(6);
    {d, c, b, a} = 4'd9;
    cyc(3);
    checks++;
    if ({row_addr, row_change} !== {4'd9, 1'b1}) begin
      errors++;
      $display("FAIL row9: got %h/%b expected 9/1", row_addr, row_change);
    end
    cyc(4);
    checks++;
    if (n_rowchg - r0 != 2) begin
      errors++;
      $display("FAIL row_change_count: got %0d expected 2", n_rowchg - r0);
    end
  endtask

  task automatic test_gclk();
    logic [15:0] exp_g;
`ifdef MATRIX_RX_GCLK_COUNT_EN
    exp_g = 16'd257;
`else
    exp_g = 16'd0;
`endif
    {d, c, b, a} = 4'd5;
    cyc(6);
    repeat (257) begin
      gclk = 1'b1;
      cyc(1);
      gclk = 1'b0;
      cyc(1);
    end
    cyc(6);
    {d, c, b, a} = 4'd6;
    cyc(4);
    checks++;
    if (row_gclks !== exp_g) begin
      errors++;
      $display("FAIL row_gclks: got %0d expected %0d", row_gclks, exp_g);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_cmd();
    test_overflow();
    test_le_only();
    test_reset_midword();
    test_row();
    test_gclk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
